// File: rtl/nibble_sorter.sv
// nibble_sorter
// Sequential N-entry bubble sorter that drives an external combinational
// magnitude comparator (one compare per clock). Values arrive on a
// valid/ready load stream and leave in sorted order on a valid/ready drain
// stream.
//
// Optional build macro: NIBBLE_SORTER_EARLY_EXIT_EN
//   defined   -> a pass finishing without any swap ends SORT immediately
//   undefined -> SORT always runs the full N(N-1)/2 compares
//
// Ports:
//   clk, rst_n                           clock, async active-low reset
//   in_valid, in_ready, in_data          load stream (ready only in LOAD)
//   out_valid, out_ready, out_data,
//   out_last                             drain stream (valid only in DRAIN)
//   cmp_a, cmp_b                         operands mem[j] / mem[j+1] to comparator
//   cmp_isbig, cmp_iseq, cmp_issmall     comparator flags (a>b, a==b, a<b)
//   busy                                 high in SORT and DRAIN
//   swap_count                           swaps performed in the current sort
//   cmp_err                              sticky: flags not one-hot during SORT
module nibble_sorter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int DESCEND = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  input  logic         cmp_isbig,
  input  logic         cmp_iseq,
  input  logic         cmp_issmall,
  output logic         busy,
  output logic [5:0]   swap_count,
  output logic         cmp_err
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] LAST_CMP = IW'(N - 2);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] pass_q, pass_d;
  logic [5:0]    swap_count_q, swap_count_d;
  logic          cmp_err_q, cmp_err_d;

  logic [IW-1:0] j_next_s;
  logic          flags_ok_s;
  logic          swap_req_s;
  logic          do_swap_s;
  logic          early_exit_s;

  // Exactly one comparator flag may be set for a trustworthy compare result.
  function automatic logic flags_one_hot(input logic [2:0] flags);
    case (flags)
      3'b001, 3'b010, 3'b100: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  assign j_next_s   = j_q + IW'(1);
  assign cmp_a      = mem_q[j_q];
  assign cmp_b      = mem_q[j_next_s];
  assign flags_ok_s = flags_one_hot({cmp_isbig, cmp_iseq, cmp_issmall});
  // iseq never requests a swap, which keeps equal values in load order.
  assign swap_req_s = (DESCEND != 0) ? cmp_issmall : cmp_isbig;
  assign do_swap_s  = (state_q == ST_SORT) && flags_ok_s && swap_req_s;

`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
  logic pass_swapped_q, pass_swapped_d;
  // Pass ends clean when neither an earlier compare nor this one swapped.
  assign early_exit_s = !(pass_swapped_q || do_swap_s);
`else
  assign early_exit_s = 1'b0;
`endif

  // Next-state and datapath update for LOAD / SORT / DRAIN.
  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    j_d          = j_q;
    pass_d       = pass_q;
    swap_count_d = swap_count_q;
    cmp_err_d    = cmp_err_q;
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
    pass_swapped_d = pass_swapped_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          mem_d[wr_idx_q] = in_data;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d     = {IW{1'b0}};
            j_d          = {IW{1'b0}};
            pass_d       = {IW{1'b0}};
            swap_count_d = 6'd0;
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
            pass_swapped_d = 1'b0;
`endif
            state_d      = ST_SORT;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end else begin
          wr_idx_d = wr_idx_q;
        end
      end
      ST_SORT: begin
        if (do_swap_s) begin
          mem_d[j_q]      = mem_q[j_next_s];
          mem_d[j_next_s] = mem_q[j_q];
          swap_count_d    = swap_count_q + 6'd1;
        end else begin
          swap_count_d = swap_count_q;
        end
        if (!flags_ok_s) begin
          cmp_err_d = 1'b1;
        end else begin
          cmp_err_d = cmp_err_q;
        end
        // Each pass shortens by one: the largest (or smallest) settles at the end.
        if (j_q == (LAST_CMP - pass_q)) begin
          j_d = {IW{1'b0}};
          if ((pass_q == LAST_CMP) || early_exit_s) begin
            rd_idx_d = {IW{1'b0}};
            state_d  = ST_DRAIN;
          end else begin
            pass_d = pass_q + IW'(1);
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
            pass_swapped_d = 1'b0;
`endif
          end
        end else begin
          j_d = j_next_s;
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
          pass_swapped_d = pass_swapped_q || do_swap_s;
`endif
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = {IW{1'b0}};
            wr_idx_d = {IW{1'b0}};
            state_d  = ST_LOAD;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end else begin
          rd_idx_d = rd_idx_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, register file, indices and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wr_idx_q     <= {IW{1'b0}};
      rd_idx_q     <= {IW{1'b0}};
      j_q          <= {IW{1'b0}};
      pass_q       <= {IW{1'b0}};
      swap_count_q <= 6'd0;
      cmp_err_q    <= 1'b0;
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
      pass_swapped_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      j_q          <= j_d;
      pass_q       <= pass_d;
      swap_count_q <= swap_count_d;
      cmp_err_q    <= cmp_err_d;
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
      pass_swapped_q <= pass_swapped_d;
`endif
    end
  end

  // Outputs decode directly from flops; out_data is zero outside DRAIN.
  assign in_ready   = (state_q == ST_LOAD);
  assign out_valid  = (state_q == ST_DRAIN);
  assign busy       = (state_q == ST_SORT) || (state_q == ST_DRAIN);
  assign out_data   = out_valid ? mem_q[rd_idx_q] : {W{1'b0}};
  assign out_last   = out_valid && (rd_idx_q == LAST_IDX);
  assign swap_count = swap_count_q;
  assign cmp_err    = cmp_err_q;

endmodule

// File: tb/tb_nibble_sorter.sv
// Directed bench for nibble_sorter: ascending DUT (dut0) and descending DUT
// (dut1), each with a behavioural comparator; dut0's flags can be forced off.
module tb_nibble_sorter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b1;
  logic       force_zero = 1'b0;

  logic       in_ready0, out_valid0, out_last0, busy0, cmp_err0;
  logic [3:0] out_data0, cmp_a0, cmp_b0;
  logic [5:0] swap_count0;
  logic       isbig0, iseq0, issmall0;
  logic       in_ready1, out_valid1, out_last1, busy1, cmp_err1;
  logic [3:0] out_data1, cmp_a1, cmp_b1;
  logic [5:0] swap_count1;
  logic       isbig1, iseq1, issmall1;

  int errors = 0;
  int checks = 0;

`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
  localparam int SORTED_CYC = 3;
`else
  localparam int SORTED_CYC = 6;
`endif

  always #5 clk = ~clk;

  assign isbig0   = !force_zero && (cmp_a0 > cmp_b0);
  assign iseq0    = !force_zero && (cmp_a0 == cmp_b0);
  assign issmall0 = !force_zero && (cmp_a0 < cmp_b0);
  assign isbig1   = (cmp_a1 > cmp_b1);
  assign iseq1    = (cmp_a1 == cmp_b1);
  assign issmall1 = (cmp_a1 < cmp_b1);

  nibble_sorter #(.N(4), .W(4), .DESCEND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_last(out_last0), .cmp_a(cmp_a0), .cmp_b(cmp_b0),
    .cmp_isbig(isbig0), .cmp_iseq(iseq0), .cmp_issmall(issmall0),
    .busy(busy0), .swap_count(swap_count0), .cmp_err(cmp_err0));

  nibble_sorter #(.N(4), .W(4), .DESCEND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_last(out_last1), .cmp_a(cmp_a1), .cmp_b(cmp_b1),
    .cmp_isbig(isbig1), .cmp_iseq(iseq1), .cmp_issmall(issmall1),
    .busy(busy1), .swap_count(swap_count1), .cmp_err(cmp_err1));

  // Load four beats, first beat in vals[15:12].
  task automatic load(input bit sel, input logic [15:0] vals);
    for (int i = 0; i < 4; i++) begin
      in_data = vals[(3-i)*4 +: 4];
      if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b0;
      if (!sel) in_valid0 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  // Count SORT cycles until out_valid rises (bounded).
  task automatic wait_sort(input bit sel, output int cyc);
    cyc = 0;
    while (((sel ? out_valid1 : out_valid0) == 1'b0) && (cyc < 50)) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Drain four beats with out_ready=1; beats lacking out_valid read as X.
  task automatic drain(input bit sel, output logic [15:0] got, output logic [3:0] lasts);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (sel ? out_valid1 : out_valid0)
        got[(3-i)*4 +: 4] = sel ? out_data1 : out_data0;
      else
        got[(3-i)*4 +: 4] = 4'bxxxx;
      lasts[3-i] = sel ? out_last1 : out_last0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
    checks++; if ({out_valid0, out_last0, busy0, cmp_err0} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {out_valid0, out_last0, busy0, cmp_err0}); end
    checks++; if (out_data0 !== 4'd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data0); end
    checks++; if (swap_count0 !== 6'd0) begin errors++; $display("FAIL reset_swap_count: got %0d want 0", swap_count0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ascending;
    int cyc; logic [15:0] got; logic [3:0] l;
    load(1'b0, 16'h5330);
    checks++; if ({busy0, in_ready0} !== 2'b10) begin errors++; $display("FAIL sort_busy_ready: got %b want 10", {busy0, in_ready0}); end
    wait_sort(1'b0, cyc);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL sort_cycles_5330: got %0d want 6", cyc); end
    checks++; if (swap_count0 !== 6'd5) begin errors++; $display("FAIL swaps_5330: got %0d want 5", swap_count0); end
    drain(1'b0, got, l);
    checks++; if (got !== 16'h0335) begin errors++; $display("FAIL drain_5330: got %h want 0335", got); end
    checks++; if (l !== 4'b0001) begin errors++; $display("FAIL last_5330: got %b want 0001", l); end
    checks++; if ({in_ready0, out_valid0} !== 2'b10) begin errors++; $display("FAIL back_to_load: got %b want 10", {in_ready0, out_valid0}); end
    checks++; if (swap_count0 !== 6'd5) begin errors++; $display("FAIL swaps_hold_load: got %0d want 5", swap_count0); end
    load(1'b0, 16'hFA60);
    wait_sort(1'b0, cyc);
    checks++; if (swap_count0 !== 6'd6) begin errors++; $display("FAIL swaps_fa60: got %0d want 6", swap_count0); end
    drain(1'b0, got, l);
    checks++; if (got !== 16'h06AF) begin errors++; $display("FAIL drain_fa60: got %h want 06af", got); end
  endtask

  task automatic test_descending;
    int cyc; logic [15:0] got; logic [3:0] l;
    load(1'b1, 16'h06AF);
    wait_sort(1'b1, cyc);
    checks++; if (swap_count1 !== 6'd6) begin errors++; $display("FAIL swaps_desc: got %0d want 6", swap_count1); end
    drain(1'b1, got, l);
    checks++; if (got !== 16'hFA60) begin errors++; $display("FAIL drain_desc: got %h want fa60", got); end
    checks++; if (l !== 4'b0001) begin errors++; $display("FAIL last_desc: got %b want 0001", l); end
  endtask

  task automatic test_presorted;
    int cyc; logic [15:0] got; logic [3:0] l;
    load(1'b0, 16'h1234);
    wait_sort(1'b0, cyc);
    checks++; if (cyc !== SORTED_CYC) begin errors++; $display("FAIL sort_cycles_sorted: got %0d want %0d", cyc, SORTED_CYC); end
    checks++; if (swap_count0 !== 6'd0) begin errors++; $display("FAIL swaps_sorted: got %0d want 0", swap_count0); end
    drain(1'b0, got, l);
    checks++; if (got !== 16'h1234) begin errors++; $display("FAIL drain_sorted: got %h want 1234", got); end
  endtask

  task automatic test_back_to_back_stall;
    int cyc;
    load(1'b0, 16'h7192);
    wait_sort(1'b0, cyc);
    checks++; if (swap_count0 !== 6'd3) begin errors++; $display("FAIL swaps_7192: got %0d want 3", swap_count0); end
    out_ready = 1'b1;
    checks++; if (out_data0 !== 4'd1) begin errors++; $display("FAIL bp_beat0: got %0d want 1", out_data0); end
    @(posedge clk); #1;
    checks++; if (out_data0 !== 4'd2) begin errors++; $display("FAIL bp_beat1: got %0d want 2", out_data0); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({out_valid0, out_data0, out_last0, in_ready0} !== {1'b1, 4'd7, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%0d l=%b r=%b want v=1 d=7 l=0 r=0", k, out_valid0, out_data0, out_last0, in_ready0);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    checks++; if (out_data0 !== 4'd7) begin errors++; $display("FAIL bp_beat2: got %0d want 7", out_data0); end
    @(posedge clk); #1;
    checks++; if ({out_data0, out_last0} !== {4'd9, 1'b1}) begin errors++; $display("FAIL bp_beat3: got %0d/%b want 9/1", out_data0, out_last0); end
    @(posedge clk); #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL bp_reload: got %b want 1", in_ready0); end
  endtask

  task automatic test_reset_mid_sort;
    int cyc; logic [15:0] got; logic [3:0] l;
    load(1'b0, 16'h3210);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy0, in_ready0, out_valid0, out_last0} !== 4'b0100) begin errors++; $display("FAIL rst_mid_flags: got %b want 0100", {busy0, in_ready0, out_valid0, out_last0}); end
    checks++; if ({swap_count0, out_data0, cmp_a0} !== 14'd0) begin errors++; $display("FAIL rst_mid_values: got sc=%0d d=%0d a=%0d want 0", swap_count0, out_data0, cmp_a0); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(1'b0, 16'h9876);
    wait_sort(1'b0, cyc);
    drain(1'b0, got, l);
    checks++; if (got !== 16'h6789) begin errors++; $display("FAIL drain_after_rst: got %h want 6789", got); end
  endtask

  task automatic test_cmp_err;
    int cyc; logic [15:0] got; logic [3:0] l;
    checks++; if (cmp_err0 !== 1'b0) begin errors++; $display("FAIL cmp_err_pre: got %b want 0", cmp_err0); end
    force_zero = 1'b1;
    load(1'b0, 16'h4321);
    wait_sort(1'b0, cyc);
    checks++; if ({cmp_err0, swap_count0} !== {1'b1, 6'd0}) begin errors++; $display("FAIL cmp_err_set: got err=%b sc=%0d want err=1 sc=0", cmp_err0, swap_count0); end
    drain(1'b0, got, l);
    checks++; if (got !== 16'h4321) begin errors++; $display("FAIL cmp_err_order: got %h want 4321", got); end
    force_zero = 1'b0;
    load(1'b0, 16'h2143);
    wait_sort(1'b0, cyc);
    drain(1'b0, got, l);
    checks++; if (got !== 16'h1234) begin errors++; $display("FAIL cmp_err_recover_sort: got %h want 1234", got); end
    checks++; if (cmp_err0 !== 1'b1) begin errors++; $display("FAIL cmp_err_sticky: got %b want 1", cmp_err0); end
    #2; rst_n = 1'b0; #1;
    checks++; if (cmp_err0 !== 1'b0) begin errors++; $display("FAIL cmp_err_reset: got %b want 0", cmp_err0); end
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_presorted();
    test_back_to_back_stall();
    test_reset_mid_sort();
    test_cmp_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
